// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the slice-sequenced wide adder: state codes,
// slice width and the slice-index width helper.
package add_seq_ctrl_pkg;

   localparam int SLICE_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Index width for n slices; never below one bit so the index register always exists.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/bit_16.sv
// Shared 16-bit ripple adder slice with carry in and carry out.
module bit_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
   end

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide add/subtract built from one 16-bit adder stepped across NUM_SLICES
// slices (LSB first) with a registered inter-slice carry and valid/ready handshakes.
module add_seq_ctrl
   import add_seq_ctrl_pkg::*;
#(
   parameter int NUM_SLICES = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [SLICE_W*NUM_SLICES-1:0]   a,
   input  logic [SLICE_W*NUM_SLICES-1:0]   b,
   input  logic                            sub,
   input  logic                            abort,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [SLICE_W*NUM_SLICES-1:0]   sum,
   output logic                            cout,
   output logic                            ovf,
   output logic                            busy
);

   localparam int W     = SLICE_W * NUM_SLICES;
   localparam int IDX_W = clog2(NUM_SLICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [SLICE_W-1:0] add_a, add_b, add_sum;
   logic               add_cout;

   assign add_a = a_q[idx_q*SLICE_W +: SLICE_W];
   assign add_b = b_q[idx_q*SLICE_W +: SLICE_W];

   bit_16 u_slice_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            // Subtract is A + ~B + 1: invert B once here and seed the carry with sub.
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end else begin
               sum_d[idx_q*SLICE_W +: SLICE_W] = add_sum;
               carry_d = add_cout;
               if (idx_q == LAST_IDX) begin
                  cout_d  = add_cout;
                  ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[SLICE_W-1] != a_q[W-1]);
                  idx_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign busy      = (state_q == ST_RUN);
   assign out_valid = (state_q == ST_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: transaction-level reference model compared every
// cycle, plus directed cases with hand-computed results.
module tb_add_seq_ctrl;

   localparam int NS = 4;
   localparam int W  = 16 * NS;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         sub = 1'b0;
   logic         abort = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, cout, ovf, busy;
   logic [W-1:0] sum;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   add_seq_ctrl #(.NUM_SLICES(NS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 7))
         0: r = '0;
         1: r = '1;
         2: r = {1'b1, {(W-1){1'b0}}};
         3: r = {1'b0, {(W-1){1'b1}}};
         default: ;
      endcase
      return r;
   endfunction

   // Reference: phase 0 = waiting for request, 1 = computing, 2 = result offered.
   int           m_phase = 0;
   int           m_cnt = 0;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;
   logic         m_ovf = 1'b0;
   logic [W:0]   m_sx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_cnt   = 0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               if (sub) begin
                  m_sum  = a - b;
                  m_cout = (a >= b);
                  m_sx   = {a[W-1], a} - {b[W-1], b};
               end else begin
                  {m_cout, m_sum} = {1'b0, a} + {1'b0, b};
                  m_sx = {a[W-1], a} + {b[W-1], b};
               end
               m_ovf   = (m_sx[W] != m_sx[W-1]);
               m_phase = 1;
               m_cnt   = 0;
            end
            1: if (abort) m_phase = 0;
               else begin
                  m_cnt++;
                  if (m_cnt == NS) m_phase = 2;
               end
            2: if (out_ready) m_phase = 0;
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", W'(in_ready), W'(m_phase == 0));
         check("busy", W'(busy), W'(m_phase == 1));
         check("out_valid", W'(out_valid), W'(m_phase == 2));
         if (m_phase == 2) begin
            check("model_sum", sum, m_sum);
            check("model_cout", W'(cout), W'(m_cout));
            check("model_ovf", W'(ovf), W'(m_ovf));
         end
      end
   end

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input bit lit, input logic [W-1:0] es, input logic ec, input logic eo,
                        input bit hold, input string nm);
      int k;
      int lat;
      logic [W-1:0] held;
      k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_accept_timeout: in_ready got 0, expected 1", nm);
         return;
      end
      a = ta; b = tb_v; sub = ts; in_valid = 1'b1; out_ready = !hold;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = rnd_word(); b = rnd_word(); sub = $urandom_range(0, 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (lat < 2) begin
            in_valid = 1'b1;
            a = rnd_word(); b = rnd_word();
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check({nm, "_latency"}, W'(lat), W'(NS));
      if (lit) begin
         check({nm, "_sum"}, sum, es);
         check({nm, "_cout"}, W'(cout), W'(ec));
         check({nm, "_ovf"}, W'(ovf), W'(eo));
      end
      if (hold) begin
         held = sum;
         repeat (3) begin
            @(posedge clk); #1;
            check({nm, "_hold_valid"}, W'(out_valid), W'(1));
            check({nm, "_hold_in_ready"}, W'(in_ready), W'(0));
            check({nm, "_hold_sum"}, sum, held);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({nm, "_drain_valid"}, W'(out_valid), W'(0));
      check({nm, "_drain_in_ready"}, W'(in_ready), W'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst_in_ready", W'(in_ready), W'(0));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_sum", sum, '0);
      check("rst_cout", W'(cout), W'(0));
      check("rst_ovf", W'(ovf), W'(0));
      #6 rst = 1'b0;
      @(posedge clk); #1;

      do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 0, "carry_slice");
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1, 64'h0, 1'b1, 1'b0, 0, "full_chain");
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, "add_ovf");
      do_op(64'h5, 64'h7, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0, "sub_neg");
      do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, "sub_ovf");
      do_op(64'h1111, 64'h2222, 1'b0, 1, 64'h3333, 1'b0, 1'b0, 1, "backpressure");

      // abort after slice 1 has been written
      a = 64'hDEAD_BEEF_0000_0001; b = 64'h5; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_in_ready", W'(in_ready), W'(1));
      check("abort_busy", W'(busy), W'(0));
      repeat (NS + 1) begin
         @(posedge clk); #1;
         check("abort_no_valid", W'(out_valid), W'(0));
      end
      do_op(64'h1, 64'h2, 1'b0, 1, 64'h3, 1'b0, 1'b0, 0, "after_abort");

      // asynchronous reset between edges during a run
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("arst_busy", W'(busy), W'(0));
      check("arst_out_valid", W'(out_valid), W'(0));
      check("arst_in_ready", W'(in_ready), W'(0));
      check("arst_sum", sum, '0);
      check("arst_cout", W'(cout), W'(0));
      check("arst_ovf", W'(ovf), W'(0));
      #1 rst = 1'b0;
      @(posedge clk); #1;
      do_op(64'h1234, 64'h1, 1'b0, 1, 64'h1235, 1'b0, 1'b0, 0, "after_reset");

      for (int i = 0; i < 30; i++) begin
         do_op(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 0, '0, 1'b0, 1'b0,
               ($urandom_range(0, 3) == 0), "random");
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
